onehot_decoder_seq: RTL and testbench

Parametrised registered successor to the 2:4 one-hot decoder. It decodes a SEL_W-bit index into a 2**SEL_W one-hot word `m` and its complement `d`. It can load the index from a valid/ready port or step it automatically up or down at a programmable rate, with blanking and a wrap pulse. It drives one-hot enables for a bank of 2**SEL_W loads, such as LEDs, mux legs or channel gates.

---
 rtl/onehot_decoder_seq.sv | 117 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot index decoder with direct load, up/down auto-scan,
// output blanking and a wrap pulse. m is the active-high one-hot word of
// the index, d its active-low complement.
module onehot_decoder_seq #(
    parameter int SEL_W    = 2,
    parameter int STEP_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   m,
    output logic [2**SEL_W-1:0]   d,
    output logic [SEL_W-1:0]      idx,
    output logic                  out_valid,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int PS_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    // The state records the mode seen on the previous edge; comparing it with
    // the live mode is what detects a mode change.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCAN_UP = 2'b01,
        SCAN_DN = 2'b10,
        HOLD    = 2'b11
    } state_t;

    state_t          state;
    state_t          mode_s;
    logic [PS_W-1:0] prescaler;

    logic [SEL_W-1:0] next_idx;
    logic [PS_W-1:0]  next_ps;
    logic             changed;
    logic             load;
    logic             step;
    logic             wrap_evt;
    logic [OUT_W-1:0] onehot_next;

    assign mode_s   = state_t'(mode);
    assign changed  = (mode_s != state);
    assign in_ready = (mode == 2'b00) && !rst;

    // Next index / prescaler and the load, step and wrap events for this edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        next_idx = idx;
        next_ps  = prescaler;
        load     = 1'b0;
        step     = 1'b0;
        wrap_evt = 1'b0;
        unique case (mode_s)
            IDLE: begin
                next_ps = '0;
                if (in_valid) begin
                    next_idx = sel;
                    load     = 1'b1;
                end
            end
            SCAN_UP, SCAN_DN: begin
                if (changed) begin
                    next_ps = '0;
                end else if (prescaler == PS_LAST) begin
                    next_ps = '0;
                    step    = 1'b1;
                    if (mode_s == SCAN_UP) begin
                        next_idx = idx + SEL_W'(1);
                        wrap_evt = (idx == IDX_MAX);
                    end else begin
                        next_idx = idx - SEL_W'(1);
                        wrap_evt = (idx == '0);
                    end
                end else begin
                    next_ps = prescaler + PS_W'(1);
                end
            end
            HOLD: begin
                next_ps = changed ? '0 : prescaler;
            end
        endcase
    end

    assign onehot_next = OUT_W'(1) << next_idx;

    // Register index, prescaler, mode history and the decoded outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            prescaler <= '0;
            m         <= OUT_W'(1);
            d         <= ~OUT_W'(1);
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= mode_s;
            idx       <= next_idx;
            prescaler <= next_ps;
            m         <= en ? onehot_next : '0;
            d         <= en ? ~onehot_next : '1;
            out_valid <= load | step;
            wrap      <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: three instances (SEL_W/STEP_DIV = 2/4, 2/1,
// 3/4) share one stimulus stream and are compared against a cycle-level
// behavioural model built from the decoder rules.
module tb_onehot_decoder_seq;

    localparam int SW[3] = '{2, 2, 3};
    localparam int DV[3] = '{4, 1, 4};

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [2:0] sel;

    logic [3:0] m_a, d_a, m_b, d_b;
    logic [7:0] m_c, d_c;
    logic [1:0] idx_a, idx_b;
    logic [2:0] idx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       ov_a, ov_b, ov_c;
    logic       wr_a, wr_b, wr_c;

    onehot_decoder_seq #(.SEL_W(2), .STEP_DIV(4)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_a), .sel(sel[1:0]), .m(m_a), .d(d_a), .idx(idx_a),
        .out_valid(ov_a), .wrap(wr_a)
    );
    onehot_decoder_seq #(.SEL_W(2), .STEP_DIV(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_b), .sel(sel[1:0]), .m(m_b), .d(d_b), .idx(idx_b),
        .out_valid(ov_b), .wrap(wr_b)
    );
    onehot_decoder_seq #(.SEL_W(3), .STEP_DIV(4)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_c), .sel(sel), .m(m_c), .d(d_c), .idx(idx_c),
        .out_valid(ov_c), .wrap(wr_c)
    );

    // Uniform 8-bit views of the three instances for looped comparisons.
    logic [7:0] mo[3], dout[3];
    logic [2:0] io[3];
    logic       vo[3], wo[3], ro[3];
    assign mo[0] = {4'b0, m_a};  assign dout[0] = {4'b0, d_a};  assign io[0] = {1'b0, idx_a};
    assign mo[1] = {4'b0, m_b};  assign dout[1] = {4'b0, d_b};  assign io[1] = {1'b0, idx_b};
    assign mo[2] = m_c;          assign dout[2] = d_c;          assign io[2] = idx_c;
    assign vo[0] = ov_a; assign vo[1] = ov_b; assign vo[2] = ov_c;
    assign wo[0] = wr_a; assign wo[1] = wr_b; assign wo[2] = wr_c;
    assign ro[0] = rdy_a; assign ro[1] = rdy_b; assign ro[2] = rdy_c;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: e_cnt counts scan cycles elapsed since the scan mode
    // was entered; a step happens whenever that count is a multiple of the
    // step divider.
    int         e_idx[3];
    int         e_cnt[3];
    logic [7:0] e_m[3];
    bit         e_ov[3];
    bit         e_wr[3];
    logic [1:0] e_prev;
    int         ow;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ow = 1 << SW[i];
            if (rst) begin
                e_idx[i] = 0;
                e_cnt[i] = 0;
                e_ov[i]  = 0;
                e_wr[i]  = 0;
            end else begin
                e_ov[i] = 0;
                e_wr[i] = 0;
                if (mode == 2'd0) begin
                    if (in_valid) begin
                        e_idx[i] = int'(sel) % ow;
                        e_ov[i]  = 1;
                    end
                end else if (mode != 2'd3) begin
                    if (mode != e_prev) begin
                        e_cnt[i] = 0;
                    end else begin
                        e_cnt[i] = e_cnt[i] + 1;
                        if (e_cnt[i] % DV[i] == 0) begin
                            e_ov[i] = 1;
                            if (mode == 2'd1) begin
                                e_wr[i]  = (e_idx[i] == ow - 1);
                                e_idx[i] = (e_idx[i] + 1) % ow;
                            end else begin
                                e_wr[i]  = (e_idx[i] == 0);
                                e_idx[i] = (e_idx[i] + ow - 1) % ow;
                            end
                        end
                    end
                end
            end
            e_m[i] = (rst || en) ? 8'(1 << e_idx[i]) : 8'h00;
        end
        e_prev = rst ? 2'd0 : mode;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'd0; in_valid = 1'b0; sel = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mo[i] !== 8'h01 || io[i] !== 3'd0 || vo[i] !== 1'b0 || wo[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d] m=%h idx=%0d ov=%b wrap=%b required m=01 idx=0 ov=0 wrap=0",
                         i, mo[i], io[i], vo[i], wo[i]);
            end
            total++;
            if (dout[i] !== (8'hFF >> (8 - (1 << SW[i]))) - 8'h01) begin
                bad++;
                $display("FAIL reset_d[%0d] d=%h", i, dout[i]);
            end
            total++;
            if (ro[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready[%0d] got=%b required=1", i, ro[i]);
            end
        end
    endtask

    task automatic test_direct();
        sel = 3'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (m_a !== 4'b0100 || d_a !== 4'b1011 || idx_a !== 2'd2 || ov_a !== 1'b1) begin
            bad++;
            $display("FAIL direct_load m=%b d=%b idx=%0d ov=%b required 0100 1011 2 1",
                     m_a, d_a, idx_a, ov_a);
        end
        total++;
        if (m_c !== 8'h04) begin
            bad++;
            $display("FAIL direct_load_w3 m=%h required=04", m_c);
        end
        tick();
        total++;
        if (ov_a !== 1'b0 || m_a !== 4'b0100) begin
            bad++;
            $display("FAIL direct_pulse ov=%b m=%b required ov=0 m=0100", ov_a, m_a);
        end
    endtask

    task automatic test_scan_up();
        logic [1:0] exp_idx;
        mode = 2'd1; in_valid = 1'b1; sel = 3'd1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            exp_idx = (k < 4) ? 2'd2 : (k < 8) ? 2'd3 : (k < 12) ? 2'd0 : 2'd1;
            total++;
            if (idx_a !== exp_idx || m_a !== 4'(1 << exp_idx) || d_a !== ~4'(1 << exp_idx)) begin
                bad++;
                $display("FAIL scan_up k=%0d idx=%0d m=%b d=%b required idx=%0d", k, idx_a, m_a, d_a, exp_idx);
            end
            total++;
            if (wr_a !== (k == 8) || ov_a !== (k == 4 || k == 8 || k == 12) || rdy_a !== 1'b0) begin
                bad++;
                $display("FAIL scan_up_pulse k=%0d wrap=%b ov=%b ready=%b", k, wr_a, ov_a, rdy_a);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_scan_down();
        logic [1:0] exp_seq[5];
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        mode = 2'd0; sel = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mode = 2'd2;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (idx_b !== exp_seq[k] || wr_b !== (k == 0 || k == 4) || ov_b !== 1'b1) begin
                bad++;
                $display("FAIL scan_down k=%0d idx=%0d wrap=%b ov=%b required idx=%0d",
                         k, idx_b, wr_b, ov_b, exp_seq[k]);
            end
        end
    endtask

    task automatic test_blank();
        mode = 2'd1;
        tick();
        tick();
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (m_a !== 4'b0000 || d_a !== 4'b1111 || int'(idx_a) !== e_idx[0] || ov_a !== e_ov[0]) begin
                bad++;
                $display("FAIL blank k=%0d m=%b d=%b idx=%0d ov=%b required m=0000 d=1111 idx=%0d ov=%b",
                         k, m_a, d_a, idx_a, ov_a, e_idx[0], e_ov[0]);
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (m_a !== 4'(1 << e_idx[0]) || int'(idx_a) !== e_idx[0]) begin
            bad++;
            $display("FAIL unblank m=%b idx=%0d required idx=%0d", m_a, idx_a, e_idx[0]);
        end
    endtask

    task automatic test_hold();
        int h;
        h = e_idx[0];
        mode = 2'd3;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (int'(idx_a) !== h || m_a !== 4'(1 << h) || ov_a !== 1'b0 || wr_a !== 1'b0) begin
                bad++;
                $display("FAIL hold k=%0d idx=%0d m=%b ov=%b wrap=%b required idx=%0d", k, idx_a, m_a, ov_a, wr_a, h);
            end
        end
        mode = 2'd1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (ov_a !== (k == 4) || int'(idx_a) !== ((k == 4) ? (h + 1) % 4 : h)) begin
                bad++;
                $display("FAIL hold_resume k=%0d ov=%b idx=%0d", k, ov_a, idx_a);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        mode = 2'd0; sel = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mode = 2'd1;
        tick();
        tick();
        total++;
        if (idx_c !== 3'd5) begin
            bad++;
            $display("FAIL pre_reset idx=%0d required=5", idx_c);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (idx_c !== 3'd0 || m_c !== 8'h01 || d_c !== 8'hFE || wr_c !== 1'b0 || ov_c !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_scan idx=%0d m=%h d=%h wrap=%b ov=%b required 0 01 FE 0 0",
                     idx_c, m_c, d_c, wr_c, ov_c);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            en       = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            in_valid = $urandom_range(0, 1) == 1;
            sel      = 3'($urandom_range(0, 7));
            tick();
            total++;
            if (ro[0] !== ((mode == 2'd0) && !rst)) begin
                bad++;
                $display("FAIL rand_ready n=%0d got=%b", n, ro[0]);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (mo[i] !== e_m[i] || dout[i] !== (~e_m[i] & 8'(((1 << (1 << SW[i])) - 1)))) begin
                    bad++;
                    $display("FAIL rand_md[%0d] n=%0d m=%h d=%h required m=%h", i, n, mo[i], dout[i], e_m[i]);
                end
                total++;
                if (int'(io[i]) !== e_idx[i] || vo[i] !== e_ov[i] || wo[i] !== e_wr[i]) begin
                    bad++;
                    $display("FAIL rand_state[%0d] n=%0d idx=%0d ov=%b wrap=%b required idx=%0d ov=%b wrap=%b",
                             i, n, io[i], vo[i], wo[i], e_idx[i], e_ov[i], e_wr[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_down();
        test_blank();
        test_hold();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
